epp_host: RTL and testbench
===========================

Name: epp_host

Overview:
- EPP bus initiator: the host end of the EPP link that comm_fpga answers as peripheral.
- Accepts byte-level commands (address write, data write, data read) over a valid/ready pipe and drives the EPP strobes and data byte.
- Returns read bytes on a second valid/ready pipe.
- Used as a bench-side host model and as the host end of FPGA-to-FPGA EPP links.

Parameters:
- SETUP_CYCLES, 2, clocks data/write are driven before strobe assertion (1..15).
- TIMEOUT_CYCLES, 1023, max clocks waiting for eppWait edge before abort (10-bit counter).

Ports:
- clk_in  input  1  system clock, all logic on rising edge
- reset_in  input  1  synchronous reset, active-high
- cmdOp_in  input  2  00=address write, 01=data write, 10=data read, 11=reserved
- cmdData_in  input  8  byte for address/data writes
- cmdValid_in  input  1  command present
- cmdReady_out  output  1  command accepted on this edge when both high
- rspData_out  output  8  byte from a data read
- rspValid_out  output  1  rspData_out valid
- rspReady_in  input  1  consumer takes response when both high
- eppData_out  output  8  driven byte
- eppDataOE_out  output  1  1 = host drives eppData (writes only)
- eppData_in  input  8  sampled bus byte
- eppAddrStb_out  output  1  active-low address strobe
- eppDataStb_out  output  1  active-low data strobe
- eppWrite_out  output  1  0 = write cycle, 1 = read
- eppWait_in  input  1  peripheral acknowledge, active-high
- busy_out  output  1  high whenever state != IDLE
- timeout_out  output  1  sticky error, set on any timeout, cleared only by reset

Behaviour:
- Reset values:
  - cmdReady_out=1
  - rspValid_out=0, rspData_out=00
  - eppAddrStb_out=1, eppDataStb_out=1, eppWrite_out=1, eppDataOE_out=0, eppData_out=00
  - busy_out=0, timeout_out=0, state IDLE
- eppWait_in passes a 2-flop synchronizer; FSM sees only waitSync (2-clock lag).
- States: IDLE, SETUP, STROBE, RELEASE, RESP.
- IDLE: cmdReady_out=1. On cmdValid_in&cmdReady_out, latch op/data, set eppWrite_out (0 for op 00/01, 1 for op 10), drive eppDataOE_out/eppData_out for writes, load counter=SETUP_CYCLES-1, go to SETUP.
  - Op 11 is accepted and discarded; stay in IDLE with no bus activity.
- cmdReady_out is 0 in every state except IDLE.
- SETUP: count down; at 0 assert the strobe (addr for op 00, data for 01/10), load timeout counter, go to STROBE.
- STROBE: wait for waitSync=1.
  - On 1: reads capture eppData_in into rspData_out on that edge. Deassert strobe, reload timeout, go to RELEASE.
  - Timeout (counter reaches 0 with waitSync=0): deassert strobe, set timeout_out, go to RELEASE; no response is produced.
- RELEASE: wait for waitSync=0.
  - Then drop eppDataOE_out, set eppWrite_out=1, and go to RESP (reads completed normally) or IDLE.
  - Timeout here sets timeout_out and forces the same exit.
- RESP: rspValid_out=1; hold rspData_out stable until rspReady_in=1, then rspValid_out=0, go to IDLE.
  - A new command is never accepted while a response is pending.
- Strobes are never both low; a strobe never falls in the same cycle data/OE/write change.
- Minimum transaction: 1 accept + SETUP_CYCLES + 2 (sync) + 1 + 2 (sync) + 1 clocks.
- Reset mid-transaction:
  - Strobes release on the next edge; pending response is discarded.
  - The peripheral is expected to drop eppWait within its own protocol.

Test Plan:
- Address write 0x00 then data write 0xA5 to a comm_fpga-style responder: eppAddrStb_out low with eppData_out=00, eppWrite_out=0; then eppDataStb_out low with A5; responder sees chanAddr=0, h2fData=A5; no rspValid_out pulse.
- Data read with responder returning 0x3C and rspReady_in held 0 for 5 clocks: rspValid_out=1, rspData_out=3C held stable; cmdReady_out=0 throughout; IDLE the clock after rspReady_in=1.
- Back-to-back commands with cmdValid_in held high: address 0x02, read, read. Two responses in order matching responder bytes (e.g. 07, 08); strobe high for ≥SETUP_CYCLES between transfers.
- eppWait_in never asserted during data write with TIMEOUT_CYCLES=15: strobe released after 15 clocks in STROBE; timeout_out=1 and stays 1; next command still runs.
- reset_in pulsed for one clock while eppDataStb_out low: next edge gives all outputs at reset values, timeout_out=0, busy_out=0.
- Op 11 issued: cmdReady_out handshake completes; no strobe activity, no response, busy_out stays 0.

Source files
------------

// File: rtl/epp_host.sv
// EPP bus initiator: turns a byte-level command stream into EPP address/data
// strobe cycles and returns data-read bytes on a response pipe.
module epp_host #(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic [1:0] cmdOp_in,
    input  logic [7:0] cmdData_in,
    input  logic       cmdValid_in,
    output logic       cmdReady_out,
    output logic [7:0] rspData_out,
    output logic       rspValid_out,
    input  logic       rspReady_in,
    output logic [7:0] eppData_out,
    output logic       eppDataOE_out,
    input  logic [7:0] eppData_in,
    output logic       eppAddrStb_out,
    output logic       eppDataStb_out,
    output logic       eppWrite_out,
    input  logic       eppWait_in,
    output logic       busy_out,
    output logic       timeout_out,
    output logic [2:0] state_out
);

    // Both pipes use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; valid holds its payload until then.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        RELEASE = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADDR  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [9:0] SETUP_LOAD   = 10'(SETUP_CYCLES - 1);
    localparam logic [9:0] TIMEOUT_LOAD = 10'(TIMEOUT_CYCLES - 1);

    state_t     state, state_d;
    logic [9:0] count, count_d;
    logic [1:0] op, op_d;
    logic       got_data, got_data_d;
    logic [7:0] rsp_data, rsp_data_d;
    logic [7:0] bus_data, bus_data_d;
    logic       bus_oe, bus_oe_d;
    logic       addr_stb, addr_stb_d;
    logic       data_stb, data_stb_d;
    logic       write_lvl, write_lvl_d;
    logic       timeout, timeout_d;
    logic       wait_meta, wait_sync;

    // eppWait comes from another clock domain; the FSM sees only wait_sync.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wait_meta <= 1'b0;
            wait_sync <= 1'b0;
        end else begin
            wait_meta <= eppWait_in;
            wait_sync <= wait_meta;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state     <= IDLE;
            count     <= 10'd0;
            op        <= OP_ADDR;
            got_data  <= 1'b0;
            rsp_data  <= 8'h00;
            bus_data  <= 8'h00;
            bus_oe    <= 1'b0;
            addr_stb  <= 1'b1;
            data_stb  <= 1'b1;
            write_lvl <= 1'b1;
            timeout   <= 1'b0;
        end else begin
            state     <= state_d;
            count     <= count_d;
            op        <= op_d;
            got_data  <= got_data_d;
            rsp_data  <= rsp_data_d;
            bus_data  <= bus_data_d;
            bus_oe    <= bus_oe_d;
            addr_stb  <= addr_stb_d;
            data_stb  <= data_stb_d;
            write_lvl <= write_lvl_d;
            timeout   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state;
        count_d     = count;
        op_d        = op;
        got_data_d  = got_data;
        rsp_data_d  = rsp_data;
        bus_data_d  = bus_data;
        bus_oe_d    = bus_oe;
        addr_stb_d  = addr_stb;
        data_stb_d  = data_stb;
        write_lvl_d = write_lvl;
        timeout_d   = timeout;

        case (state)
            IDLE: begin
                // Reserved op is consumed by the handshake and dropped.
                if (cmdValid_in && cmdOp_in != OP_RSVD) begin
                    op_d        = cmdOp_in;
                    got_data_d  = 1'b0;
                    write_lvl_d = (cmdOp_in == OP_READ);
                    bus_oe_d    = (cmdOp_in != OP_READ);
                    bus_data_d  = (cmdOp_in != OP_READ) ? cmdData_in : 8'h00;
                    count_d     = SETUP_LOAD;
                    state_d     = SETUP;
                end
            end

            SETUP: begin
                if (count == 10'd0) begin
                    if (op == OP_ADDR) begin
                        addr_stb_d = 1'b0;
                    end else begin
                        data_stb_d = 1'b0;
                    end
                    count_d = TIMEOUT_LOAD;
                    state_d = STROBE;
                end else begin
                    count_d = count - 10'd1;
                end
            end

            STROBE: begin
                if (wait_sync) begin
                    if (op == OP_READ) begin
                        rsp_data_d = eppData_in;
                        got_data_d = 1'b1;
                    end
                    addr_stb_d = 1'b1;
                    data_stb_d = 1'b1;
                    count_d    = TIMEOUT_LOAD;
                    state_d    = RELEASE;
                end else if (count == 10'd0) begin
                    addr_stb_d = 1'b1;
                    data_stb_d = 1'b1;
                    timeout_d  = 1'b1;
                    count_d    = TIMEOUT_LOAD;
                    state_d    = RELEASE;
                end else begin
                    count_d = count - 10'd1;
                end
            end

            RELEASE: begin
                if (!wait_sync || count == 10'd0) begin
                    if (wait_sync) begin
                        timeout_d = 1'b1;
                    end
                    bus_oe_d    = 1'b0;
                    bus_data_d  = 8'h00;
                    write_lvl_d = 1'b1;
                    state_d     = got_data ? RESP : IDLE;
                end else begin
                    count_d = count - 10'd1;
                end
            end

            RESP: begin
                if (rspReady_in) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmdReady_out   = (state == IDLE);
    assign rspValid_out   = (state == RESP);
    assign busy_out       = (state != IDLE);
    assign rspData_out    = rsp_data;
    assign eppData_out    = bus_data;
    assign eppDataOE_out  = bus_oe;
    assign eppAddrStb_out = addr_stb;
    assign eppDataStb_out = data_stb;
    assign eppWrite_out   = write_lvl;
    assign timeout_out    = timeout;
    assign state_out      = state;

endmodule

// File: tb/tb_epp_host.sv
// Directed bench for epp_host with a comm_fpga-style EPP responder.
`timescale 1ns/1ps
module tb_epp_host;

    localparam int SETUP = 2;
    localparam int TOUT  = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] epp_data_out;
    logic       epp_oe;
    logic [7:0] epp_data_in;
    logic       addr_stb;
    logic       data_stb;
    logic       epp_write;
    logic       epp_wait;
    logic       busy;
    logic       timeout;
    logic [2:0] state_dbg;

    epp_host #(
        .SETUP_CYCLES   (SETUP),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk_in         (clk),
        .reset_in       (rst),
        .cmdOp_in       (cmd_op),
        .cmdData_in     (cmd_data),
        .cmdValid_in    (cmd_valid),
        .cmdReady_out   (cmd_ready),
        .rspData_out    (rsp_data),
        .rspValid_out   (rsp_valid),
        .rspReady_in    (rsp_ready),
        .eppData_out    (epp_data_out),
        .eppDataOE_out  (epp_oe),
        .eppData_in     (epp_data_in),
        .eppAddrStb_out (addr_stb),
        .eppDataStb_out (data_stb),
        .eppWrite_out   (epp_write),
        .eppWait_in     (epp_wait),
        .busy_out       (busy),
        .timeout_out    (timeout),
        .state_out      (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rd_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- responder model ----------------
    logic       resp_en = 1'b1;
    logic [7:0] chan_addr = 8'hFF;
    logic [7:0] h2f_data = 8'h00;
    logic       addr_wr_seen = 1'b1;

    initial begin
        epp_wait    = 1'b0;
        epp_data_in = 8'h00;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                if (!epp_wait && (!addr_stb || !data_stb)) begin
                    if (!addr_stb) begin
                        addr_wr_seen = epp_write;
                        if (!epp_write) chan_addr = epp_data_out;
                    end else if (!epp_write) begin
                        h2f_data = epp_data_out;
                    end else if (rd_q.size() > 0) begin
                        epp_data_in = rd_q.pop_front();
                    end
                    epp_wait = 1'b1;
                end else if (epp_wait && addr_stb && data_stb) begin
                    epp_wait = 1'b0;
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    int   stb_falls = 0, both_low = 0, edge_viol = 0, stb_low_cycles = 0;
    int   rsp_valid_cycles = 0, busy_total = 0, high_run = 0, min_gap = 1000;
    logic prev_a = 1'b1, prev_d = 1'b1, prev_oe = 1'b0, prev_wr = 1'b1;
    logic [7:0] prev_data = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!addr_stb && !data_stb) both_low++;
            if (!addr_stb || !data_stb) stb_low_cycles++;
            if (busy) busy_total++;
            if (rsp_valid) rsp_valid_cycles++;
            if ((prev_a && !addr_stb) || (prev_d && !data_stb)) begin
                stb_falls++;
                if (epp_data_out !== prev_data || epp_oe !== prev_oe || epp_write !== prev_wr)
                    edge_viol++;
                if (high_run < min_gap) min_gap = high_run;
            end
            if (addr_stb && data_stb) high_run++;
            else high_run = 0;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
                else check("rsp_data", rsp_data, exp_q.pop_front());
            end
            prev_a    = addr_stb;
            prev_d    = data_stb;
            prev_oe   = epp_oe;
            prev_wr   = epp_write;
            prev_data = epp_data_out;
        end
    end

    // ---------------- driver tasks ----------------
    // Leaves cmd_valid high; callers drop it once the follow-up is decided.
    task automatic send_cmd(input logic [1:0] op, input logic [7:0] d);
        int n;
        cmd_op    = op;
        cmd_data  = d;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("cmd_accept_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", 1, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int falls0, rv0, busy0;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp", {rsp_valid, rsp_data}, 9'h000);
        check("rst_bus", {addr_stb, data_stb, epp_write, epp_oe, epp_data_out}, 12'hE00);
        check("rst_busy_timeout", {busy, timeout}, 2'b00);
        check("rst_state", state_dbg, 0);
        rst = 1'b0;
        @(negedge clk);

        // address write 0x00, then data write 0xA5
        rsp_ready = 1'b1;
        send_cmd(2'b00, 8'h00);
        cmd_valid = 1'b0;
        wait_idle(n);
        check("addr_chan", chan_addr, 8'h00);
        check("addr_write_level", addr_wr_seen, 0);
        send_cmd(2'b01, 8'hA5);
        cmd_valid = 1'b0;
        wait_idle(n);
        check("wr_busy_cycles", n, SETUP + 6);
        check("wr_h2f_data", h2f_data, 8'hA5);
        check("wr_no_rsp", rsp_valid_cycles, 0);

        // data read 0x3C with consumer stalled for 5 clocks
        rsp_ready = 1'b0;
        rd_q.push_back(8'h3C);
        exp_q.push_back(8'h3C);
        send_cmd(2'b10, 8'h00);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("rd_rsp_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            check("rd_hold", {rsp_valid, cmd_ready, rsp_data}, {1'b1, 1'b0, 8'h3C});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rd_idle_after_ready", {busy, rsp_valid, cmd_ready}, 3'b001);

        // back-to-back: address 0x02, read, read with valid held high
        rd_q.push_back(8'h07);
        rd_q.push_back(8'h08);
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h08);
        send_cmd(2'b00, 8'h02);
        send_cmd(2'b10, 8'h00);
        send_cmd(2'b10, 8'h00);
        cmd_valid = 1'b0;
        wait_idle(n);
        repeat (2) @(negedge clk);
        check("b2b_chan", chan_addr, 8'h02);
        check("b2b_rsp_drained", exp_q.size(), 0);

        // peripheral never acknowledges a data write
        resp_en = 1'b0;
        stb_low_cycles = 0;
        send_cmd(2'b01, 8'h5A);
        cmd_valid = 1'b0;
        wait_idle(n);
        check("to_strobe_cycles", stb_low_cycles, TOUT);
        check("to_flag", timeout, 1);
        check("to_no_capture", h2f_data, 8'hA5);
        resp_en = 1'b1;
        send_cmd(2'b01, 8'h33);
        cmd_valid = 1'b0;
        wait_idle(n);
        check("to_next_cmd", h2f_data, 8'h33);
        check("to_sticky", timeout, 1);

        // reset while the data strobe is low
        send_cmd(2'b01, 8'hC3);
        cmd_valid = 1'b0;
        n = 0;
        while (data_stb && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_stb_seen", data_stb, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_bus", {addr_stb, data_stb, epp_write, epp_oe, epp_data_out}, 12'hE00);
        check("mid_rst_flags", {busy, timeout, cmd_ready, rsp_valid}, 4'b0010);
        repeat (5) @(negedge clk);

        // reserved op is accepted and dropped
        falls0 = stb_falls;
        rv0    = rsp_valid_cycles;
        busy0  = busy_total;
        send_cmd(2'b11, 8'hEE);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("rsvd_no_strobe", stb_falls, falls0);
        check("rsvd_no_rsp", rsp_valid_cycles, rv0);
        check("rsvd_no_busy", busy_total, busy0);
        check("rsvd_ready", cmd_ready, 1);

        check("never_both_low", both_low, 0);
        check("strobe_edge_clean", edge_viol, 0);
        check("strobe_gap_ok", (min_gap >= SETUP), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
